// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port data memory arbiter and command sequencer
// Define DM_ARB_RR_EN for round-robin arbitration instead of fixed-priority A with a B starvation guard.
module dm_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 2048,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_re,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_wrt_data,
  input  logic [DATA_W-1:0] dm_rd_data
);

  logic sel_b;

`ifdef DM_ARB_RR_EN
  // last_b starts set so that A wins the first contended cycle after reset
  logic last_b;
  assign sel_b = b_req && (!a_req || !last_b);

  always_ff @(posedge clk) begin
    if (!rst_n)     last_b <= 1'b1;
    else if (a_gnt) last_b <= 1'b0;
    else if (b_gnt) last_b <= 1'b1;
  end
`else
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] wait_cnt;
  assign sel_b = b_req && (!a_req || wait_cnt == WAIT_W'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (!rst_n || !b_req || b_gnt)           wait_cnt <= '0;
    else if (wait_cnt != WAIT_W'(MAX_WAIT))  wait_cnt <= wait_cnt + 1'b1;
  end
`endif

  assign b_gnt = rst_n && sel_b;
  assign a_gnt = rst_n && a_req && !sel_b;

  logic              any_gnt;
  logic              win_we;
  logic              win_ok;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  assign any_gnt   = a_gnt || b_gnt;
  assign win_we    = sel_b ? b_we    : a_we;
  assign win_addr  = sel_b ? b_addr  : a_addr;
  assign win_wdata = sel_b ? b_wdata : a_wdata;
  assign win_ok    = 32'(win_addr) < 32'(DEPTH);

  // command stage bookkeeping, carried alongside dm_* to route the completion
  logic cmd_vld;
  logic cmd_b;
  logic cmd_err;
  logic cmd_rd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dm_re       <= 1'b0;
      dm_we       <= 1'b0;
      dm_addr     <= '0;
      dm_wrt_data <= '0;
      cmd_vld     <= 1'b0;
      cmd_b       <= 1'b0;
      cmd_err     <= 1'b0;
      cmd_rd      <= 1'b0;
    end else begin
      cmd_vld <= any_gnt;
      dm_re   <= any_gnt && win_ok && !win_we;
      dm_we   <= any_gnt && win_ok && win_we;
      if (any_gnt) begin
        cmd_b       <= sel_b;
        cmd_err     <= !win_ok;
        cmd_rd      <= !win_we;
        dm_addr     <= win_addr;
        dm_wrt_data <= win_wdata;
      end
    end
  end

  // completion stage: read data is captured at the end of the command cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_done  <= 1'b0;
      b_done  <= 1'b0;
      a_err   <= 1'b0;
      b_err   <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      a_done <= cmd_vld && !cmd_b;
      b_done <= cmd_vld && cmd_b;
      a_err  <= cmd_vld && !cmd_b && cmd_err;
      b_err  <= cmd_vld && cmd_b && cmd_err;
      if (cmd_vld && !cmd_b && (cmd_err || cmd_rd))
        a_rdata <= cmd_err ? '0 : dm_rd_data;
      if (cmd_vld && cmd_b && (cmd_err || cmd_rd))
        b_rdata <= cmd_err ? '0 : dm_rd_data;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - self-checking bench for dm_arbiter with a reference arbitration/memory model
module tb_dm_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int DEPTH    = 2048;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, a_gnt, a_done, a_err;
  logic [12:0] a_addr;
  logic [15:0] a_wdata, a_rdata;
  logic        b_req, b_we, b_gnt, b_done, b_err;
  logic [12:0] b_addr;
  logic [15:0] b_wdata, b_rdata;
  logic [12:0] dm_addr;
  logic        dm_re, dm_we;
  logic [15:0] dm_wrt_data, dm_rd_data;

  int total = 0;
  int bad = 0;

  logic [15:0] mem     [0:DEPTH-1];
  logic [15:0] ref_mem [0:DEPTH-1];

  dm_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata), .b_err(b_err),
    .dm_addr(dm_addr), .dm_re(dm_re), .dm_we(dm_we),
    .dm_wrt_data(dm_wrt_data), .dm_rd_data(dm_rd_data)
  );

  always #5 clk = ~clk;

  // single-ported data memory, operating on the falling edge
  always @(negedge clk) begin
    if (dm_we) mem[dm_addr] = dm_wrt_data;
    if (dm_re) dm_rd_data = mem[dm_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 13'h0; a_wdata = 16'h0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 13'h0; b_wdata = 16'h0;
    tick(); tick(); #2;
    total++; if ({a_gnt, b_gnt} !== 2'b00) begin bad++; $display("FAIL rst_gnt got=%b exp=00", {a_gnt, b_gnt}); end
    total++; if ({dm_re, dm_we} !== 2'b00) begin bad++; $display("FAIL rst_dm_en got=%b exp=00", {dm_re, dm_we}); end
    total++; if (dm_addr !== 13'h0 || dm_wrt_data !== 16'h0) begin bad++; $display("FAIL rst_dm_bus got=%h/%h exp=0/0", dm_addr, dm_wrt_data); end
    total++; if ({a_done, b_done, a_err, b_err} !== 4'b0) begin bad++; $display("FAIL rst_done_err got=%b exp=0000", {a_done, b_done, a_err, b_err}); end
    total++; if (a_rdata !== 16'h0 || b_rdata !== 16'h0) begin bad++; $display("FAIL rst_rdata got=%h/%h exp=0/0", a_rdata, b_rdata); end
    a_req = 1'b0; b_req = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_a_write_read();
    tick();
    a_req = 1'b1; a_we = 1'b1; a_addr = 13'h0123; a_wdata = 16'hBEEF; #2;
    total++; if ({a_gnt, b_gnt} !== 2'b10) begin bad++; $display("FAIL awr_gnt got=%b exp=10", {a_gnt, b_gnt}); end
    tick();
    a_we = 1'b0; #2;
    total++; if ({dm_we, dm_re} !== 2'b10) begin bad++; $display("FAIL awr_cmd_en got=%b exp=10", {dm_we, dm_re}); end
    total++; if (dm_addr !== 13'h0123 || dm_wrt_data !== 16'hBEEF) begin bad++; $display("FAIL awr_cmd_bus got=%h/%h exp=0123/beef", dm_addr, dm_wrt_data); end
    total++; if (a_gnt !== 1'b1) begin bad++; $display("FAIL ard_gnt got=%b exp=1", a_gnt); end
    tick();
    a_req = 1'b0; #2;
    total++; if ({a_done, a_err} !== 2'b10) begin bad++; $display("FAIL awr_done got=%b exp=10", {a_done, a_err}); end
    total++; if ({dm_re, dm_we} !== 2'b10 || dm_addr !== 13'h0123) begin bad++; $display("FAIL ard_cmd got=%b/%h exp=10/0123", {dm_re, dm_we}, dm_addr); end
    tick(); #2;
    total++; if (a_done !== 1'b1 || a_rdata !== 16'hBEEF) begin bad++; $display("FAIL ard_done got=%b/%h exp=1/beef", a_done, a_rdata); end
    total++; if ({dm_re, dm_we} !== 2'b00) begin bad++; $display("FAIL ard_idle_en got=%b exp=00", {dm_re, dm_we}); end
    tick(); #2;
    total++; if (a_done !== 1'b0 || a_rdata !== 16'hBEEF) begin bad++; $display("FAIL ard_hold got=%b/%h exp=0/beef", a_done, a_rdata); end
  endtask

  task automatic test_b_write_read();
    tick();
    b_req = 1'b1; b_we = 1'b1; b_addr = 13'h07FF; b_wdata = 16'h5A5A; #2;
    total++; if ({a_gnt, b_gnt} !== 2'b01) begin bad++; $display("FAIL bwr_gnt got=%b exp=01", {a_gnt, b_gnt}); end
    tick();
    b_we = 1'b0; #2;
    total++; if (dm_we !== 1'b1 || dm_addr !== 13'h07FF || dm_wrt_data !== 16'h5A5A) begin bad++; $display("FAIL bwr_cmd got=%b/%h/%h exp=1/07ff/5a5a", dm_we, dm_addr, dm_wrt_data); end
    tick();
    b_req = 1'b0; #2;
    total++; if ({b_done, b_err, a_done} !== 3'b100) begin bad++; $display("FAIL bwr_done got=%b exp=100", {b_done, b_err, a_done}); end
    tick(); #2;
    total++; if (b_done !== 1'b1 || b_rdata !== 16'h5A5A) begin bad++; $display("FAIL brd_done got=%b/%h exp=1/5a5a", b_done, b_rdata); end
    total++; if (a_done !== 1'b0 || a_rdata !== 16'hBEEF) begin bad++; $display("FAIL brd_a_untouched got=%b/%h exp=0/beef", a_done, a_rdata); end
    tick();
  endtask

  task automatic test_out_of_range();
    tick();
    b_req = 1'b1; b_we = 1'b0; b_addr = 13'h0800; #2;
    total++; if (b_gnt !== 1'b1) begin bad++; $display("FAIL oor_gnt got=%b exp=1", b_gnt); end
    tick();
    b_req = 1'b0; #2;
    total++; if ({dm_re, dm_we} !== 2'b00) begin bad++; $display("FAIL oor_cmd_en got=%b exp=00", {dm_re, dm_we}); end
    tick(); #2;
    total++; if ({b_done, b_err} !== 2'b11 || b_rdata !== 16'h0) begin bad++; $display("FAIL oor_done got=%b/%h exp=11/0000", {b_done, b_err}, b_rdata); end
    tick(); #2;
    total++; if ({b_done, b_err} !== 2'b00) begin bad++; $display("FAIL oor_clear got=%b exp=00", {b_done, b_err}); end
  endtask

  task automatic test_reset_mid_op();
    tick();
    a_req = 1'b1; a_we = 1'b0; a_addr = 13'h0123; #2;
    total++; if (a_gnt !== 1'b1) begin bad++; $display("FAIL rmid_gnt got=%b exp=1", a_gnt); end
    #1 rst_n = 1'b0;
    tick(); #2;
    total++; if ({dm_re, dm_we, a_gnt, a_done} !== 4'b0) begin bad++; $display("FAIL rmid_first got=%b exp=0000", {dm_re, dm_we, a_gnt, a_done}); end
    total++; if (dm_addr !== 13'h0 || a_rdata !== 16'h0 || b_rdata !== 16'h0) begin bad++; $display("FAIL rmid_regs got=%h/%h/%h exp=0/0/0", dm_addr, a_rdata, b_rdata); end
    a_req = 1'b0;
    tick(); #2;
    total++; if ({a_done, b_done, a_err, b_err} !== 4'b0) begin bad++; $display("FAIL rmid_no_done got=%b exp=0000", {a_done, b_done, a_err, b_err}); end
    rst_n = 1'b1;
    tick(); #2;
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL rmid_no_late_done got=%b exp=0", a_done); end
  endtask

  task automatic test_contention();
    logic exp_b;
    a_we = 1'b0; a_addr = 13'h0010; b_we = 1'b0; b_addr = 13'h0020;
    for (int i = 0; i < 10; i++) begin
      tick();
      a_req = 1'b1; b_req = 1'b1; #2;
`ifdef DM_ARB_RR_EN
      exp_b = (i % 2) == 1;
`else
      exp_b = (i % (MAX_WAIT + 1)) == MAX_WAIT;
`endif
      total++; if ({a_gnt, b_gnt} !== {!exp_b, exp_b}) begin bad++; $display("FAIL contend_%0d got=%b exp=%b", i, {a_gnt, b_gnt}, {!exp_b, exp_b}); end
    end
    tick();
    a_req = 1'b0; b_req = 1'b0;
    tick(); tick(); tick();
  endtask

  typedef struct {
    bit          v;
    bit          b;
    bit          we;
    bit          err;
    logic [12:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } op_t;

  task automatic test_random();
    op_t         rec [4];
    op_t         p;
    op_t         d;
    bit          a_pend, b_pend, ea, eb, exp_re, exp_we;
    logic [12:0] na [2];
    logic [15:0] nd [2];
    bit          nw [2];
    logic [15:0] exp_a_rdata, exp_b_rdata;
    int          b_denied;
    bit          last_was_b;
    for (int i = 0; i < 4; i++) rec[i] = '{default: '0};
    a_pend = 1'b0; b_pend = 1'b0;
    exp_a_rdata = 16'h0; exp_b_rdata = 16'h0;
    b_denied = 0; last_was_b = 1'b1;
    na[0] = 13'h0; na[1] = 13'h0; nd[0] = 16'h0; nd[1] = 16'h0; nw[0] = 1'b0; nw[1] = 1'b0;
    rst_n = 1'b0; a_req = 1'b0; b_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 600; k++) begin
      tick();
      a_req = a_pend; a_we = nw[0]; a_addr = na[0]; a_wdata = nd[0];
      b_req = b_pend; b_we = nw[1]; b_addr = na[1]; b_wdata = nd[1];
      #2;
`ifdef DM_ARB_RR_EN
      eb = b_pend && (!a_pend || !last_was_b);
      ea = a_pend && !eb;
      if (ea) last_was_b = 1'b0;
      else if (eb) last_was_b = 1'b1;
`else
      eb = b_pend && (!a_pend || b_denied >= MAX_WAIT);
      ea = a_pend && !eb;
      if (b_pend && !eb) b_denied = (b_denied < MAX_WAIT) ? b_denied + 1 : MAX_WAIT;
      else b_denied = 0;
`endif
      total++; if ({a_gnt, b_gnt} !== {ea, eb}) begin bad++; $display("FAIL rnd_gnt k=%0d got=%b exp=%b", k, {a_gnt, b_gnt}, {ea, eb}); end

      p = rec[(k + 3) % 4];
      exp_re = p.v && !p.err && !p.we;
      exp_we = p.v && !p.err && p.we;
      total++; if ({dm_re, dm_we} !== {exp_re, exp_we}) begin bad++; $display("FAIL rnd_cmd_en k=%0d got=%b exp=%b", k, {dm_re, dm_we}, {exp_re, exp_we}); end
      if (exp_re || exp_we) begin
        total++; if (dm_addr !== p.addr) begin bad++; $display("FAIL rnd_cmd_addr k=%0d got=%h exp=%h", k, dm_addr, p.addr); end
      end
      if (exp_we) begin
        total++; if (dm_wrt_data !== p.wdata) begin bad++; $display("FAIL rnd_cmd_wdata k=%0d got=%h exp=%h", k, dm_wrt_data, p.wdata); end
      end

      d = rec[(k + 2) % 4];
      if (d.v && (d.err || !d.we)) begin
        if (d.b) exp_b_rdata = d.rdata;
        else     exp_a_rdata = d.rdata;
      end
      total++; if ({a_done, a_err} !== {d.v && !d.b, d.v && !d.b && d.err}) begin bad++; $display("FAIL rnd_a_done k=%0d got=%b exp=%b", k, {a_done, a_err}, {d.v && !d.b, d.v && !d.b && d.err}); end
      total++; if ({b_done, b_err} !== {d.v && d.b, d.v && d.b && d.err}) begin bad++; $display("FAIL rnd_b_done k=%0d got=%b exp=%b", k, {b_done, b_err}, {d.v && d.b, d.v && d.b && d.err}); end
      total++; if (a_rdata !== exp_a_rdata || b_rdata !== exp_b_rdata) begin bad++; $display("FAIL rnd_rdata k=%0d got=%h/%h exp=%h/%h", k, a_rdata, b_rdata, exp_a_rdata, exp_b_rdata); end

      rec[k % 4] = '{default: '0};
      if (ea || eb) begin
        rec[k % 4].v     = 1'b1;
        rec[k % 4].b     = eb;
        rec[k % 4].we    = nw[eb ? 1 : 0];
        rec[k % 4].addr  = na[eb ? 1 : 0];
        rec[k % 4].wdata = nd[eb ? 1 : 0];
        rec[k % 4].err   = 32'(rec[k % 4].addr) >= DEPTH;
        if (!rec[k % 4].err && !rec[k % 4].we) rec[k % 4].rdata = ref_mem[rec[k % 4].addr];
        if (!rec[k % 4].err && rec[k % 4].we) ref_mem[rec[k % 4].addr] = rec[k % 4].wdata;
      end
      if (ea) a_pend = 1'b0;
      if (eb) b_pend = 1'b0;
      for (int q = 0; q < 2; q++) begin
        if (!(q == 0 ? a_pend : b_pend) && $urandom_range(0, 9) < 6) begin
          nw[q] = 1'($urandom_range(0, 1));
          nd[q] = 16'($urandom);
          if ($urandom_range(0, 7) == 0) na[q] = 13'(DEPTH + $urandom_range(0, 6143));
          else na[q] = 13'(512 + $urandom_range(0, 15));
          if (q == 0) a_pend = 1'b1;
          else b_pend = 1'b1;
        end
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    tick(); tick(); tick();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 16'h0;
      ref_mem[i] = 16'h0;
    end
    test_reset();
    test_a_write_read();
    test_b_write_read();
    test_out_of_range();
    test_reset_mid_op();
    test_contention();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
